// File: rtl/rr_mux41_arbiter_if.sv
// Shared 4:1 mux / tristate path: requester-side and arbiter-side signal bundle.
interface rr_mux41_arbiter_if #(
   parameter int unsigned DW = 1
);
   logic [3:0]      req;
   logic [4*DW-1:0] din;
   logic [3:0]      grant;
   logic            s1;
   logic            s0;
   logic            bus_en;
   logic [DW-1:0]   dout;

   modport master (
      output req, din,
      input  grant, s1, s0, bus_en, dout
   );

   modport slave (
      input  req, din,
      output grant, s1, s0, bus_en, dout
   );
endinterface

// File: rtl/rr_mux41_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux / tristate path, with a one-cycle dead slot
// between owners and a burst limit while others are waiting.
module rr_mux41_arbiter #(
   parameter int unsigned DW        = 1,
   parameter int unsigned MAX_BURST = 4
) (
   input logic               clk,
   input logic               rst,
   rr_mux41_arbiter_if.slave bus
);
   localparam int unsigned   CW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StGrant  = 2'd1;
   localparam logic [1:0] StSwitch = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    grant_q, grant_d;
   logic [1:0]    sel_q, sel_d;
   logic          bus_en_q, bus_en_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    last_q, last_d;

   logic [1:0] pick;
   logic       any_req;
   logic       others_req;
   logic       leave;

   // Search last+1 .. last+3; descending order lets the nearest hit win. Falls back to last.
   always_comb begin
      pick = last_q;
      for (int k = 3; k >= 1; k--) begin
         if (bus.req[last_q + 2'(k)]) pick = last_q + 2'(k);
      end
   end

   assign any_req    = |bus.req;
   assign others_req = |(bus.req & ~(4'b0001 << sel_q));
   assign leave      = !bus.req[sel_q] || ((cnt_q == CNT_MAX) && others_req);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      bus_en_d = bus_en_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      case (state_q)
         StIdle, StSwitch: begin
            if (any_req) begin
               state_d  = StGrant;
               grant_d  = 4'b0001 << pick;
               sel_d    = pick;
               bus_en_d = 1'b1;
               cnt_d    = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StGrant: begin
            if (leave) begin
               // Selects are held through the dead slot so the mux never glitches.
               state_d  = StSwitch;
               grant_d  = 4'b0000;
               bus_en_d = 1'b0;
               last_d   = sel_q;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d  = StIdle;
            grant_d  = 4'b0000;
            bus_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= 4'b0000;
         sel_q    <= 2'b00;
         bus_en_q <= 1'b0;
         cnt_q    <= '0;
         last_q   <= 2'd3;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         bus_en_q <= bus_en_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   always_comb begin
      bus.dout = '0;
      for (int i = 0; i < 4; i++) begin
         if (bus_en_q && (sel_q == 2'(i))) bus.dout = bus.din[i*DW +: DW];
      end
   end

   assign bus.grant  = grant_q;
   assign bus.s1     = sel_q[1];
   assign bus.s0     = sel_q[0];
   assign bus.bus_en = bus_en_q;
endmodule

// File: tb/tb_rr_mux41_arbiter.sv
// Scoreboard bench for rr_mux41_arbiter: expected {grant,s1,s0,bus_en,dout} queued per edge.
module tb_rr_mux41_arbiter;
   localparam int unsigned DW        = 1;
   localparam int unsigned MAX_BURST = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_mux41_arbiter_if #(.DW(DW)) bus ();

   rr_mux41_arbiter #(
      .DW        (DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] pk(logic [3:0] g, logic [1:0] s, logic e, logic d);
      return {g, s, e, d};
   endfunction

   function automatic logic [7:0] observed();
      return {bus.grant, bus.s1, bus.s0, bus.bus_en, bus.dout};
   endfunction

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = 4'b0000;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst     = 1'b1;
      bus.req = 4'b1111;
      bus.din = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(pk(4'b0000, 2'b00, 1'b0, 1'b0));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL reset step %0d: got %b want %b", i, observed(), e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [3:0] rq[6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100};
      logic [7:0] ex[6];
      logic [7:0] e;
      ex = '{pk(4'b0000, 2'b00, 1'b0, 1'b0), pk(4'b0100, 2'b10, 1'b1, 1'b1),
             pk(4'b0100, 2'b10, 1'b1, 1'b1), pk(4'b0000, 2'b10, 1'b0, 1'b0),
             pk(4'b0000, 2'b10, 1'b0, 1'b0), pk(4'b0100, 2'b10, 1'b1, 1'b1)};
      do_reset();
      bus.din = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         bus.req = rq[i];
         exp_q.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL single step %0d: got %b want %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_rotate();
      logic [3:0] dv = 4'b1010;
      logic [7:0] e;
      int         step = 0;
      do_reset();
      bus.din = dv;
      bus.req = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            if (c < 4) exp_q.push_back(pk(4'b0001 << (r % 4), 2'(r % 4), 1'b1, dv[r % 4]));
            else       exp_q.push_back(pk(4'b0000, 2'(r % 4), 1'b0, 1'b0));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (observed() !== e) begin
               n_err++;
               $display("FAIL rotate cycle %0d: got %b want %b", step, observed(), e);
            end
            step++;
         end
      end
   endtask

   task automatic test_hold();
      logic [7:0] e;
      do_reset();
      bus.din = 4'b0001;
      bus.req = 4'b0001;
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(pk(4'b0001, 2'b00, 1'b1, 1'b1));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL hold cycle %0d: got %b want %b", i, observed(), e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] dv = 4'b0110;
      logic [7:0] e;
      do_reset();
      bus.din = dv;
      for (int i = 0; i < 14; i++) begin
         if (i < 12) begin
            bus.req = 4'b1111;
            if (i < 4)       exp_q.push_back(pk(4'b0001, 2'b00, 1'b1, dv[0]));
            else if (i == 4) exp_q.push_back(pk(4'b0000, 2'b00, 1'b0, 1'b0));
            else if (i < 9)  exp_q.push_back(pk(4'b0010, 2'b01, 1'b1, dv[1]));
            else if (i == 9) exp_q.push_back(pk(4'b0000, 2'b01, 1'b0, 1'b0));
            else             exp_q.push_back(pk(4'b0100, 2'b10, 1'b1, dv[2]));
         end else if (i == 12) begin
            rst = 1'b1;
            exp_q.push_back(pk(4'b0000, 2'b00, 1'b0, 1'b0));
         end else begin
            rst     = 1'b0;
            bus.req = 4'b1010;
            exp_q.push_back(pk(4'b0010, 2'b01, 1'b1, dv[1]));
         end
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL reset_mid step %0d: got %b want %b", i, observed(), e);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_handover();
      logic [3:0] rq[6] = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
      logic [7:0] ex[6];
      logic [7:0] e;
      ex = '{pk(4'b0001, 2'b00, 1'b1, 1'b1), pk(4'b0001, 2'b00, 1'b1, 1'b1),
             pk(4'b0000, 2'b00, 1'b0, 1'b0), pk(4'b1000, 2'b11, 1'b1, 1'b1),
             pk(4'b0000, 2'b11, 1'b0, 1'b0), pk(4'b0000, 2'b11, 1'b0, 1'b0)};
      do_reset();
      bus.din = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         bus.req = rq[i];
         exp_q.push_back(ex[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL handover step %0d: got %b want %b", i, observed(), e);
         end
      end
   endtask

   // Owner 1 hits its burst limit, then is the sole requester during the dead slot.
   task automatic test_back_to_back();
      logic [7:0] e;
      do_reset();
      bus.din = 4'b0011;
      for (int i = 0; i < 13; i++) begin
         bus.req = (i < 10) ? 4'b0011 : 4'b0010;
         if (i < 4)       exp_q.push_back(pk(4'b0001, 2'b00, 1'b1, 1'b1));
         else if (i == 4) exp_q.push_back(pk(4'b0000, 2'b00, 1'b0, 1'b0));
         else if (i < 9)  exp_q.push_back(pk(4'b0010, 2'b01, 1'b1, 1'b1));
         else if (i == 9) exp_q.push_back(pk(4'b0000, 2'b01, 1'b0, 1'b0));
         else             exp_q.push_back(pk(4'b0010, 2'b01, 1'b1, 1'b1));
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_cmp++;
         if (observed() !== e) begin
            n_err++;
            $display("FAIL back_to_back step %0d: got %b want %b", i, observed(), e);
         end
      end
   endtask

   initial begin
      bus.req = 4'b0000;
      bus.din = '0;
      test_reset();
      test_single();
      test_rotate();
      test_hold();
      test_reset_mid();
      test_handover();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rr_mux41_arbiter.md
Name: rr_mux41_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 mux / tristate output path among four requesters. It drives the mux selects s1,s0 and the output-enable line, and forwards the granted requester's data. A mandatory one-cycle dead slot between grants guarantees no two tristate drivers are ever enabled together. A burst limit bounds how long any one requester may hold the path while others wait.

Parameters:
DW, 1, data width per requester
MAX_BURST, 4, max consecutive grant cycles while another requester is waiting (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
req  input  4  request per requester; held high for the whole transfer
din  input  4*DW  requester data, slice i = din[i*DW +: DW]
grant  output  4  one-hot grant, registered
s1  output  1  mux select MSB, registered
s0  output  1  mux select LSB, registered
bus_en  output  1  output-path enable, registered; high only in GRANT
dout  output  DW  din slice {s1,s0} when bus_en=1, else all zeros (combinational from registered selects)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst), sampled on rising clk edge only.
- Reset values: state=IDLE, grant=0000, s1=0, s0=0, bus_en=0, dout=0, burst counter=0, last pointer=3 (so requester 0 has top priority first).
- States: IDLE, GRANT, SWITCH.
- Round-robin pick: first i with req[i]=1, searching last+1, last+2, last+3, last (mod 4).
- IDLE: req=0000 -> stay. Otherwise at the edge go to GRANT: grant=onehot(pick), {s1,s0}=pick, bus_en=1, counter=0. Latency: req sampled at edge k -> grant visible after edge k.
- GRANT: counter increments each cycle, saturating at MAX_BURST-1. Leave at the edge when either:
  - req[current]=0, or
  - counter==MAX_BURST-1 and some other req bit is 1.
- Leaving GRANT goes to SWITCH: grant=0000, bus_en=0, {s1,s0} held, last=current.
- If the current requester is the only one requesting, it keeps the grant indefinitely; counter saturates and no SWITCH occurs.
- SWITCH lasts exactly one cycle:
  - req!=0000 -> GRANT with a fresh round-robin pick, counter=0. The same requester may be re-granted if it is the only one requesting.
  - req=0000 -> IDLE.
- s1,s0 change only on the IDLE->GRANT and SWITCH->GRANT edges. bus_en is never high in the cycle immediately after a select change from a different owner.
- Simultaneous events:
  - Current req drop plus a new req in the same cycle -> SWITCH, then the new requester.
  - Reset has priority over every transition.
- Reset mid-GRANT: all outputs take reset values at that edge; pointer returns to 3.
- Invariants: grant is one-hot or zero. bus_en == |grant. grant[{s1,s0}]==1 whenever bus_en=1.

Test Plan:
1. rst=1 for 2 cycles with req=1111 -> grant=0000, s1s0=00, bus_en=0, dout=0 throughout.
2. DW=1, req=0100, din[2]=1 -> after one edge grant=0100, s1s0=10, bus_en=1, dout=1. Drop req -> next cycle SWITCH (bus_en=0), then IDLE.
3. MAX_BURST=4, req=1111 held -> grant sequence 0001,0010,0100,1000,0001. Each owner holds 4 cycles followed by one bus_en=0 cycle; period is 20 cycles.
4. req=0001 held 12 cycles -> grant=0001 and bus_en=1 continuously after the first edge, with no dead cycle.
5. req=1111, reset pulsed during requester 2's grant, then req=1010 -> outputs reset at that edge, then grant=0010 (pointer restarted at 3).
6. Owner 0 drops req in the same cycle req[3] rises -> one SWITCH cycle (bus_en=0, s1s0 stays 00), then grant=1000, s1s0=11.
